cordic_scheduler: RTL and testbench

CORDIC_SCHEDULER -- requirements
Module: cordic_scheduler

---
 rtl/cordic_pkg.sv | 20 ++
 rtl/cordic_tag_fifo.sv | 52 +++++
 rtl/cordic_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_cordic_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared CORDIC types: operation mode encoding and scheduler FSM states.
package cordic_pkg;

  typedef logic signed [1:0] mode_t;

  localparam mode_t HYPERBOLIC = -2'sd1;
  localparam mode_t LINEAR     = 2'sd0;
  localparam mode_t CIRCULAR   = 2'sd1;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Requester id width; a single requester still needs one bit of storage.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cordic_tag_fifo.sv
// Tag FIFO tracking in-flight CORDIC operations; pop data is the current head.
module cordic_tag_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok    = i_push && !o_full;
  assign pop_ok     = i_pop && !o_empty;
  assign o_full     = (count == FULL_CNT);
  assign o_empty    = (count == '0);
  assign o_pop_data = mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr] <= i_push_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cordic_scheduler.sv
// Round-robin scheduler sharing one CORDIC pipeline among N_REQ requesters;
// tags travel alongside the pipeline in a FIFO so results return to their owner.
module cordic_scheduler
  import cordic_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int BITS      = 33,
  parameter int LATENCY   = 32,
  parameter int TAG_DEPTH = 64
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [N_REQ-1:0]           i_req_valid,
  output logic [N_REQ-1:0]           o_req_ready,
  input  logic [N_REQ-1:0][BITS-1:0] i_req_x,
  input  logic [N_REQ-1:0][BITS-1:0] i_req_y,
  input  logic [N_REQ-1:0][BITS-1:0] i_req_z,
  input  mode_t [N_REQ-1:0]          i_req_mode,
  input  logic [N_REQ-1:0]           i_req_rot_en,
  output logic                       o_cd_ready,
  output logic [BITS-1:0]            o_cd_x,
  output logic [BITS-1:0]            o_cd_y,
  output logic [BITS-1:0]            o_cd_z,
  output mode_t                      o_cd_mode,
  output logic                       o_cd_rot_en,
  input  logic                       i_cd_valid,
  input  logic [BITS-1:0]            i_cd_x,
  input  logic [BITS-1:0]            i_cd_y,
  input  logic [BITS-1:0]            i_cd_z,
  input  mode_t                      i_cd_mode,
  input  logic                       i_cd_rot_en,
  output logic [N_REQ-1:0]           o_rsp_valid,
  output logic [BITS-1:0]            o_rsp_x,
  output logic [BITS-1:0]            o_rsp_y,
  output logic [BITS-1:0]            o_rsp_z,
  output mode_t                      o_rsp_mode,
  output logic                       o_rsp_rot_en,
  input  logic                       i_drain,
  output logic                       o_drained,
  output logic                       o_busy,
  output logic                       o_err
);

  localparam int IDW  = id_width(N_REQ);
  localparam int TAGW = IDW + 3;
  // A FIFO shallower than the pipeline would throttle issue; round it up if so.
  localparam int FIFO_DEPTH = (TAG_DEPTH >= LATENCY + 2) ? TAG_DEPTH : 2 ** $clog2(LATENCY + 2);

  state_t          state;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  cand;
  logic [IDW-1:0]  grant_id;
  logic            grant_vld;
  logic            can_grant;
  logic            fifo_full;
  logic            fifo_empty;
  logic            pop;
  logic [TAGW-1:0] push_tag;
  logic [TAGW-1:0] pop_tag;
  logic [IDW-1:0]  pop_id;
  mode_t           pop_mode;
  logic            pop_rot_en;
  logic [N_REQ-1:0] rsp_onehot;

  // Reset gates the grant so o_req_ready is low while i_rst is held.
  assign can_grant = !i_rst && (state == RUN) && !i_drain && !fifo_full;

  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = IDW'((int'(rr_ptr) + i) % N_REQ);
      if (!grant_vld && i_req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_id  = cand;
      end
    end
    if (!can_grant) grant_vld = 1'b0;
  end

  always_comb begin
    o_req_ready = '0;
    for (int k = 0; k < N_REQ; k++) begin
      o_req_ready[k] = grant_vld && (grant_id == IDW'(k));
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rr_ptr      <= '0;
      o_cd_ready  <= 1'b0;
      o_cd_x      <= '0;
      o_cd_y      <= '0;
      o_cd_z      <= '0;
      o_cd_mode   <= LINEAR;
      o_cd_rot_en <= 1'b0;
    end else begin
      o_cd_ready <= grant_vld;
      if (grant_vld) begin
        rr_ptr      <= (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
        o_cd_x      <= i_req_x[grant_id];
        o_cd_y      <= i_req_y[grant_id];
        o_cd_z      <= i_req_z[grant_id];
        o_cd_mode   <= i_req_mode[grant_id];
        o_cd_rot_en <= i_req_rot_en[grant_id];
      end
    end
  end

  assign push_tag = {grant_id, i_req_mode[grant_id], i_req_rot_en[grant_id]};
  assign pop      = i_cd_valid && !fifo_empty;

  cordic_tag_fifo #(
    .WIDTH (TAGW),
    .DEPTH (FIFO_DEPTH)
  ) u_tag_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (grant_vld),
    .i_push_data (push_tag),
    .i_pop       (pop),
    .o_pop_data  (pop_tag),
    .o_full      (fifo_full),
    .o_empty     (fifo_empty)
  );

  assign pop_id     = pop_tag[TAGW-1:3];
  assign pop_mode   = mode_t'(pop_tag[2:1]);
  assign pop_rot_en = pop_tag[0];

  always_comb begin
    rsp_onehot = '0;
    for (int k = 0; k < N_REQ; k++) begin
      rsp_onehot[k] = (pop_id == IDW'(k));
    end
  end

  // A result with no tag is dropped; a tag/result disagreement is still delivered.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rsp_valid  <= '0;
      o_rsp_x      <= '0;
      o_rsp_y      <= '0;
      o_rsp_z      <= '0;
      o_rsp_mode   <= LINEAR;
      o_rsp_rot_en <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      o_rsp_valid <= '0;
      if (pop) begin
        o_rsp_valid  <= rsp_onehot;
        o_rsp_x      <= i_cd_x;
        o_rsp_y      <= i_cd_y;
        o_rsp_z      <= i_cd_z;
        o_rsp_mode   <= i_cd_mode;
        o_rsp_rot_en <= i_cd_rot_en;
        if ((i_cd_mode != pop_mode) || (i_cd_rot_en != pop_rot_en)) o_err <= 1'b1;
      end else if (i_cd_valid) begin
        o_err <= 1'b1;
      end
    end
  end

  // state | meaning
  // RUN   | grants allowed ; DRAIN | no new grants, in-flight work completes
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     if (i_drain)  state <= DRAIN;
        DRAIN:   if (!i_drain) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  assign o_drained = (state == DRAIN) && fifo_empty && !o_cd_ready && (o_rsp_valid == '0);
  assign o_busy    = !fifo_empty || o_cd_ready || (o_rsp_valid != '0);

endmodule

// File: tb/tb_cordic_scheduler.sv
// Directed bench for cordic_scheduler with a delay-line CORDIC model.
module tb_cordic_scheduler;
  import cordic_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       req_valid, req_ready, req_rot_en;
  logic [3:0][32:0] req_x, req_y, req_z;
  mode_t [3:0]      req_mode;
  logic             cd_ready, cd_rot_en_o;
  logic [32:0]      cd_x_o, cd_y_o, cd_z_o;
  mode_t            cd_mode_o;
  logic             cd_valid, cd_rot_en_i;
  logic [32:0]      cd_x_i, cd_y_i, cd_z_i;
  mode_t            cd_mode_i;
  logic [3:0]       rsp_valid;
  logic [32:0]      rsp_x, rsp_y, rsp_z;
  mode_t            rsp_mode;
  logic             rsp_rot_en;
  logic             drain, drained, busy, err;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int mdl_delay = 32;
  int ci, ni;

  logic        slot_v [256];
  logic [32:0] slot_x [256];
  logic [32:0] slot_y [256];
  logic [32:0] slot_z [256];
  mode_t       slot_m [256];
  logic        slot_r [256];

  localparam logic [32:0] X025 = 33'h0_1000_0000;
  localparam logic [32:0] Z015 = 33'd161061274;

  cordic_scheduler #(.N_REQ(4), .BITS(33), .LATENCY(32), .TAG_DEPTH(64)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_x(req_x), .i_req_y(req_y), .i_req_z(req_z),
    .i_req_mode(req_mode), .i_req_rot_en(req_rot_en),
    .o_cd_ready(cd_ready), .o_cd_x(cd_x_o), .o_cd_y(cd_y_o), .o_cd_z(cd_z_o),
    .o_cd_mode(cd_mode_o), .o_cd_rot_en(cd_rot_en_o),
    .i_cd_valid(cd_valid), .i_cd_x(cd_x_i), .i_cd_y(cd_y_i), .i_cd_z(cd_z_i),
    .i_cd_mode(cd_mode_i), .i_cd_rot_en(cd_rot_en_i),
    .o_rsp_valid(rsp_valid), .o_rsp_x(rsp_x), .o_rsp_y(rsp_y), .o_rsp_z(rsp_z),
    .o_rsp_mode(rsp_mode), .o_rsp_rot_en(rsp_rot_en),
    .i_drain(drain), .o_drained(drained), .o_busy(busy), .o_err(err)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
    $fatal(1, "watchdog");
  end

  // CORDIC stand-in: an issue seen in cycle c returns as i_cd_valid in cycle c+delay.
  initial begin
    for (int i = 0; i < 256; i++) slot_v[i] = 1'b0;
    cd_valid = 1'b0; cd_x_i = '0; cd_y_i = '0; cd_z_i = '0; cd_mode_i = LINEAR; cd_rot_en_i = 1'b0;
    forever begin
      @(negedge clk);
      ci = cyc % 256;
      cd_valid = slot_v[ci]; cd_x_i = slot_x[ci]; cd_y_i = slot_y[ci]; cd_z_i = slot_z[ci];
      cd_mode_i = slot_m[ci]; cd_rot_en_i = slot_r[ci];
      slot_v[ci] = 1'b0;
      if (cd_ready) begin
        ni = (cyc + mdl_delay) % 256;
        slot_v[ni] = 1'b1; slot_x[ni] = cd_x_o; slot_y[ni] = cd_y_o; slot_z[ni] = cd_z_o;
        slot_m[ni] = cd_mode_o; slot_r[ni] = cd_rot_en_o;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  function automatic mode_t kmode(input int k);
    return (k == 1) ? CIRCULAR : (k == 2) ? HYPERBOLIC : LINEAR;
  endfunction

  initial begin
    int s, c0, d, e, g, n;
    rst = 1'b1; drain = 1'b0; req_valid = '0; req_rot_en = '0;
    req_x = '0; req_y = '0; req_z = '0;
    for (int k = 0; k < 4; k++) req_mode[k] = LINEAR;

    // reset state, with requests present
    wait_cyc(1);
    req_valid = 4'hF;
    #1;
    chk("rst_ready", req_ready, 4'h0);
    chk("rst_cd_ready", cd_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 4'h0);
    chk("rst_err", err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_drained", drained, 1'b0);
    req_valid = '0;
    wait_cyc(2);
    rst = 1'b0;

    // single LINEAR rotation from requester 0
    wait_cyc(10);
    req_valid = 4'b0001; req_x[0] = X025; req_y[0] = '0; req_z[0] = Z015;
    req_mode[0] = LINEAR; req_rot_en[0] = 1'b1;
    #1;
    chk("a_ready", req_ready, 4'b0001);
    wait_cyc(11);
    req_valid = '0;
    #1;
    chk("a_cd_ready", cd_ready, 1'b1);
    chk("a_cd_x", cd_x_o, X025);
    chk("a_cd_z", cd_z_o, Z015);
    chk("a_cd_mode", cd_mode_o, LINEAR);
    chk("a_cd_rot", cd_rot_en_o, 1'b1);
    chk("a_busy", busy, 1'b1);
    wait_cyc(12);
    chk("a_cd_ready_pulse", cd_ready, 1'b0);
    wait_cyc(43);
    chk("a_rsp_early", rsp_valid, 4'b0000);
    wait_cyc(44);
    chk("a_rsp_valid", rsp_valid, 4'b0001);
    chk("a_rsp_x", rsp_x, X025);
    chk("a_rsp_z", rsp_z, Z015);
    chk("a_rsp_mode", rsp_mode, LINEAR);
    chk("a_rsp_rot", rsp_rot_en, 1'b1);
    wait_cyc(45);
    chk("a_rsp_pulse", rsp_valid, 4'b0000);
    chk("a_idle_busy", busy, 1'b0);
    chk("a_err", err, 1'b0);

    // all four requesters continuously for 8 cycles
    do_reset();
    s = cyc + 2;
    for (int i = 0; i < 8; i++) begin
      wait_cyc(s + i);
      req_valid = 4'hF;
      for (int k = 0; k < 4; k++) begin
        req_x[k] = 33'(i * 16 + k); req_y[k] = 33'(100 + i); req_z[k] = 33'(k);
        req_mode[k] = kmode(k); req_rot_en[k] = k[0];
      end
      #1;
      chk("b_ready", req_ready, 4'b0001 << (i % 4));
    end
    wait_cyc(s + 8);
    req_valid = '0;
    wait_cyc(s + 33);
    chk("b_rsp_early", rsp_valid, 4'b0000);
    for (int i = 0; i < 8; i++) begin
      wait_cyc(s + 34 + i);
      chk("b_rsp_valid", rsp_valid, 4'b0001 << (i % 4));
      chk("b_rsp_x", rsp_x, 33'(i * 16 + i % 4));
      chk("b_rsp_mode", rsp_mode, kmode(i % 4));
    end
    wait_cyc(s + 42);
    chk("b_rsp_done", rsp_valid, 4'b0000);

    // slow pipeline: tag FIFO fills after 64 grants
    mdl_delay = 80;
    do_reset();
    c0 = cyc + 2;
    for (int i = 0; i < 83; i++) begin
      wait_cyc(c0 + i);
      req_valid = 4'hF;
      for (int k = 0; k < 4; k++) begin
        req_x[k] = 33'(i); req_mode[k] = kmode(k); req_rot_en[k] = k[0];
      end
      #1;
      if (i < 64)      chk("c_ready_fill", req_ready, 4'b0001 << (i % 4));
      else if (i < 82) chk("c_ready_full", req_ready, 4'b0000);
      else             chk("c_ready_after_pop", req_ready, 4'b0001);
    end
    wait_cyc(c0 + 83);
    req_valid = '0;
    wait_cyc(c0 + 100);
    chk("c_err_mid", err, 1'b0);
    wait_cyc(c0 + 166);
    chk("c_err_end", err, 1'b0);
    chk("c_busy_end", busy, 1'b0);
    mdl_delay = 32;

    // drain with 5 operations in flight
    d = cyc + 2;
    for (int i = 0; i < 5; i++) begin
      wait_cyc(d + i);
      req_valid = 4'b0100; req_x[2] = 33'(500 + i); req_mode[2] = CIRCULAR; req_rot_en[2] = 1'b0;
      #1;
      chk("d_ready", req_ready, 4'b0100);
    end
    wait_cyc(d + 5);
    drain = 1'b1;
    #1;
    chk("d_ready_same_cycle", req_ready, 4'b0000);
    chk("d_drained_early", drained, 1'b0);
    for (int i = 6; i < 38; i++) begin
      wait_cyc(d + i);
      chk("d_ready_held", req_ready, 4'b0000);
    end
    chk("d_drained_inflight", drained, 1'b0);
    wait_cyc(d + 38);
    chk("d_rsp5", rsp_valid, 4'b0100);
    chk("d_rsp5_x", rsp_x, 33'd504);
    chk("d_drained_rsp", drained, 1'b0);
    wait_cyc(d + 39);
    chk("d_drained", drained, 1'b1);
    chk("d_busy", busy, 1'b0);
    wait_cyc(d + 40);
    drain = 1'b0;
    #1;
    n = 0;
    while (req_ready == 4'b0000 && n < 4) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("d_resume", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = '0;
    wait_cyc(cyc + 45);
    chk("d_err", err, 1'b0);

    // stray result with an empty FIFO
    e = cyc + 1;
    wait_cyc(e);
    chk("e_err_before", err, 1'b0);
    slot_x[(e + 2) % 256] = 33'd7; slot_y[(e + 2) % 256] = '0; slot_z[(e + 2) % 256] = '0;
    slot_m[(e + 2) % 256] = LINEAR; slot_r[(e + 2) % 256] = 1'b0;
    slot_v[(e + 2) % 256] = 1'b1;
    wait_cyc(e + 3);
    chk("e_rsp_dropped", rsp_valid, 4'b0000);
    chk("e_err_set", err, 1'b1);
    wait_cyc(e + 10);
    chk("e_err_sticky", err, 1'b1);
    chk("e_busy", busy, 1'b0);

    // reset with 3 operations in flight
    do_reset();
    g = cyc + 2;
    wait_cyc(g - 1);
    chk("f_err_cleared", err, 1'b0);
    for (int i = 0; i < 3; i++) begin
      wait_cyc(g + i);
      req_valid = 4'hF;
      for (int k = 0; k < 4; k++) begin
        req_x[k] = 33'(700 + k); req_mode[k] = kmode(k); req_rot_en[k] = k[0];
      end
      #1;
      chk("f_ready", req_ready, 4'b0001 << i);
    end
    wait_cyc(g + 3);
    req_valid = '0;
    #1;
    chk("f_cd_ready_pre", cd_ready, 1'b1);
    #1;
    rst = 1'b1;
    req_valid = 4'hF;
    #1;
    chk("f_rst_ready", req_ready, 4'b0000);
    chk("f_rst_cd_ready", cd_ready, 1'b0);
    chk("f_rst_busy", busy, 1'b0);
    chk("f_rst_rsp", rsp_valid, 4'b0000);
    req_valid = '0;
    wait_cyc(g + 4);
    rst = 1'b0;
    wait_cyc(g + 33);
    chk("f_err_before_stray", err, 1'b0);
    wait_cyc(g + 34);
    chk("f_err_stray", err, 1'b1);
    chk("f_stray_rsp", rsp_valid, 4'b0000);
    wait_cyc(g + 36);
    chk("f_stray_rsp_last", rsp_valid, 4'b0000);
    wait_cyc(g + 40);
    req_valid = 4'hF;
    #1;
    chk("f_rr_ptr_zero", req_ready, 4'b0001);
    wait_cyc(g + 41);
    req_valid = '0;
    wait_cyc(g + 80);
    chk("f_err_final", err, 1'b1);
    chk("f_busy_final", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
